lfsr_input_conditioner: RTL

Input conditioning stage that sits directly upstream of the LFSR block on the TinyTapeout pins. It takes the two raw push-buttons (load initial state, load taps) and the raw 5-bit DIP switch bus. It debounces all of them, turns each button press into a single-cycle load pulse, and presents a stable data bus. The LFSR therefore sees exactly one load per press, with a data value that cannot glitch while that load is taken.

---
 rtl/lfsr_input_conditioner_pkg.sv | 13 +
 rtl/lfsr_input_conditioner_if.sv | 32 +++
 rtl/lfsr_input_conditioner_debounce_channel.sv | 74 +++++++
 rtl/lfsr_input_conditioner.sv | 55 +++++
 4 files changed

// File: rtl/lfsr_input_conditioner_pkg.sv
// Shared constants for the LFSR input conditioner and the LFSR itself.
// Also holds the width rule for the debounce counters.
package mbikovitsky_pkg;

  localparam int LFSR_BITS              = 5;
  localparam int DEFAULT_DEBOUNCE_TICKS = 10;

  // Counter must hold DEBOUNCE_TICKS-1; never narrower than one bit.
  function automatic int debounce_cnt_w(input int ticks);
    return (ticks > 1) ? $clog2(ticks) : 1;
  endfunction

endpackage

// File: rtl/lfsr_input_conditioner_if.sv
// Pin-side bundle between the raw TinyTapeout inputs and the conditioned
// LFSR controls. The conditioner uses the slave modport.
interface lfsr_input_conditioner_if #(
  parameter int WIDTH = mbikovitsky_pkg::LFSR_BITS
);

  logic             load_state_raw_i;
  logic             load_taps_raw_i;
  logic [WIDTH-1:0] data_raw_i;
  logic             reset_lfsr_o;
  logic             reset_taps_o;
  logic [WIDTH-1:0] data_o;

  modport slave (
    input  load_state_raw_i,
    input  load_taps_raw_i,
    input  data_raw_i,
    output reset_lfsr_o,
    output reset_taps_o,
    output data_o
  );

  modport master (
    output load_state_raw_i,
    output load_taps_raw_i,
    output data_raw_i,
    input  reset_lfsr_o,
    input  reset_taps_o,
    input  data_o
  );

endinterface

// File: rtl/lfsr_input_conditioner_debounce_channel.sv
// One debounce channel: optional 2-flop synchronizer (LFSR_INPUT_CONDITIONER_SYNC_EN),
// counter-based acceptance of changes, and a registered 0->1 pulse on bit 0.
module debounce_channel
  import mbikovitsky_pkg::*;
#(
  parameter int WIDTH          = 1,
  parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS
) (
  input  logic             clk,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] raw_i,
  output logic [WIDTH-1:0] stable_o,
  output logic             rise_o
);

  localparam int             CNT_W    = debounce_cnt_w(DEBOUNCE_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);

  logic [WIDTH-1:0] sampled;

`ifdef LFSR_INPUT_CONDITIONER_SYNC_EN
  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  assign sampled = sync2_q;
`else
  assign sampled = raw_i;
`endif

  logic [WIDTH-1:0] stable_q, stable_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             rise_q, rise_d;

  // Any mismatch keeps counting, even if sampled moves to a third value.
  always_comb begin
    stable_d = stable_q;
    count_d  = '0;
    rise_d   = 1'b0;
    if (sampled != stable_q) begin
      if (count_q == CNT_LAST) begin
        stable_d = sampled;
        rise_d   = sampled[0] & ~stable_q[0];
      end else begin
        count_d  = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      stable_q <= '0;
      count_q  <= '0;
      rise_q   <= 1'b0;
    end else begin
      stable_q <= stable_d;
      count_q  <= count_d;
      rise_q   <= rise_d;
    end
  end

  assign stable_o = stable_q;
  assign rise_o   = rise_q;

endmodule

// File: rtl/lfsr_input_conditioner.sv
// Debounces the two load buttons and the data switches feeding the LFSR.
// Define LFSR_INPUT_CONDITIONER_SYNC_EN to add 2-flop synchronizers on every input.
module lfsr_input_conditioner
  import mbikovitsky_pkg::*;
#(
  parameter int WIDTH          = LFSR_BITS,
  parameter int DEBOUNCE_TICKS = DEFAULT_DEBOUNCE_TICKS
) (
  input logic                     clk,
  input logic                     reset_i,
  lfsr_input_conditioner_if.slave bus
);

  logic             unused_state_stable;
  logic             unused_taps_stable;
  logic             unused_data_rise;
  logic [WIDTH-1:0] data_stable;

  debounce_channel #(
    .WIDTH          (1),
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
  ) u_state (
    .clk      (clk),
    .reset_i  (reset_i),
    .raw_i    (bus.load_state_raw_i),
    .stable_o (unused_state_stable),
    .rise_o   (bus.reset_lfsr_o)
  );

  debounce_channel #(
    .WIDTH          (1),
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
  ) u_taps (
    .clk      (clk),
    .reset_i  (reset_i),
    .raw_i    (bus.load_taps_raw_i),
    .stable_o (unused_taps_stable),
    .rise_o   (bus.reset_taps_o)
  );

  // The bus is accepted as one word so the LFSR never sees a partial update.
  debounce_channel #(
    .WIDTH          (WIDTH),
    .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
  ) u_data (
    .clk      (clk),
    .reset_i  (reset_i),
    .raw_i    (bus.data_raw_i),
    .stable_o (data_stable),
    .rise_o   (unused_data_rise)
  );

  assign bus.data_o = data_stable;

endmodule
